// File: rtl/vmicro16_rst_ctrl.sv
// Reset controller for vmicro16 board tops: power-on hold, debounced button and
// software re-entry, staggered per-domain release and a sticky reset-cause record.
module vmicro16_rst_ctrl #(
    parameter int POR_CLKS       = 8,
    parameter int DEBOUNCE_CLKS  = 1000,
    parameter int NUM_DOMAINS    = 2,
    parameter int STAGE_CLKS     = 4,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn,
    input  logic                   soft_req,
    input  logic                   cause_clr,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   busy,
    output logic [2:0]             cause
);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    localparam int MAX_A   = (POR_CLKS > DEBOUNCE_CLKS) ? POR_CLKS : DEBOUNCE_CLKS;
    localparam int SPAN    = NUM_DOMAINS * STAGE_CLKS + 1;
    localparam int MAX_CNT = (MAX_A > SPAN) ? MAX_A : SPAN;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] POR_LAST   = CW'(POR_CLKS - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CLKS - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'((NUM_DOMAINS - 1) * STAGE_CLKS);
    // Pin level seen while the button is not pressed.
    localparam logic BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    state_t                   state_q, state_d;
    logic                     btn_s1_q, btn_s1_d;
    logic                     btn_s2_q, btn_s2_d;
    logic                     btn_db_q, btn_db_d;
    logic [CW-1:0]            db_cnt_q, db_cnt_d;
    logic [CW-1:0]            hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]            stage_cnt_q, stage_cnt_d;
    logic [NUM_DOMAINS-1:0]   rst_out_q, rst_out_d;
    logic                     busy_q, busy_d;
    logic [2:0]               cause_q, cause_d;
    logic                     btn_lvl_s;
    logic                     set_btn_s;
    logic                     set_soft_s;

    // Synchronise the button, correct its polarity and debounce it.
    always_comb begin
        btn_s1_d  = btn;
        btn_s2_d  = btn_s1_q;
        btn_lvl_s = (btn_s2_q != BTN_IDLE);
        btn_db_d  = btn_db_q;
        db_cnt_d  = CNT_ZERO;
        if (btn_lvl_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_lvl_s;
                db_cnt_d = CNT_ZERO;
            end else begin
                db_cnt_d = db_cnt_q + CNT_ONE;
            end
        end else begin
            db_cnt_d = CNT_ZERO;
        end
    end

    // Sequencer next state, domain resets and cause set events.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stage_cnt_d = stage_cnt_q;
        rst_out_d   = rst_out_q;
        set_btn_s   = 1'b0;
        set_soft_s  = 1'b0;
        case (state_q)
            S_HOLD: begin
                rst_out_d   = '1;
                stage_cnt_d = CNT_ZERO;
                // A pressed button restarts the minimum hold from zero.
                if (btn_db_q) begin
                    hold_cnt_d = CNT_ZERO;
                end else if (hold_cnt_q >= POR_LAST) begin
                    state_d    = S_RELEASE;
                    hold_cnt_d = CNT_ZERO;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (btn_db_q) begin
                    state_d     = S_HOLD;
                    rst_out_d   = '1;
                    hold_cnt_d  = CNT_ZERO;
                    stage_cnt_d = CNT_ZERO;
                    set_btn_s   = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (stage_cnt_q == CW'(i * STAGE_CLKS)) begin
                            rst_out_d[i] = 1'b0;
                        end else begin
                            rst_out_d[i] = rst_out_q[i];
                        end
                    end
                    // One extra cycle after the last domain clears before RUN.
                    if (stage_cnt_q > STAGE_LAST) begin
                        state_d     = S_RUN;
                        stage_cnt_d = CNT_ZERO;
                    end else begin
                        stage_cnt_d = stage_cnt_q + CNT_ONE;
                    end
                end
            end
            S_RUN: begin
                rst_out_d = '0;
                if (btn_db_q || soft_req) begin
                    state_d    = S_HOLD;
                    rst_out_d  = '1;
                    hold_cnt_d = CNT_ZERO;
                    set_btn_s  = btn_db_q;
                    set_soft_s = soft_req;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d     = S_HOLD;
                rst_out_d   = '1;
                hold_cnt_d  = CNT_ZERO;
                stage_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Busy tracks the upcoming state; set events override a same-cycle clear.
    always_comb begin
        busy_d = (state_d != S_RUN);
        if (cause_clr) begin
            cause_d = 3'b000;
        end else begin
            cause_d = cause_q;
        end
        cause_d = cause_d | {set_soft_s, set_btn_s, 1'b0};
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HOLD;
            btn_s1_q    <= BTN_IDLE;
            btn_s2_q    <= BTN_IDLE;
            btn_db_q    <= 1'b0;
            db_cnt_q    <= CNT_ZERO;
            hold_cnt_q  <= CNT_ZERO;
            stage_cnt_q <= CNT_ZERO;
            rst_out_q   <= '1;
            busy_q      <= 1'b1;
            cause_q     <= 3'b001;
        end else begin
            state_q     <= state_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            btn_db_q    <= btn_db_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            rst_out_q   <= rst_out_d;
            busy_q      <= busy_d;
            cause_q     <= cause_d;
        end
    end

    assign rst_out = rst_out_q;
    assign busy    = busy_q;
    assign cause   = cause_q;

endmodule
